// File: rtl/layernorm_stats_pkg.sv
// Shared types and width helpers for the LayerNorm row-statistics stage.
package layernorm_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NUM      = 3'd1,
    ST_DIV_MEAN = 3'd2,
    ST_DIV_VAR  = 3'd3,
    ST_OUT      = 3'd4
  } state_t;

  localparam int     DEFAULT_INPUT_NUM    = 768;
  localparam longint DEFAULT_INPUT_NUM_SQ = 589824;

  function automatic int sum_width(input int iw, input int n);
    return iw + $clog2(n);
  endfunction

  function automatic int sq_width(input int iw, input int n);
    return 2 * iw + $clog2(n);
  endfunction

endpackage

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, Q_W cycles.
// quotient is valid (combinationally) in the cycle where done is high.
module seq_restoring_div #(
  parameter int NUM_W = 52,
  parameter int DEN_W = 20,
  parameter int Q_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CW    = NUM_W + DEN_W;
  localparam int CNT_W = $clog2(Q_W);

  logic [NUM_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    dsh_q, dsh_d;
  logic [Q_W-1:0]   q_q, q_d, q_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ge;

  always_comb begin
    ge       = CW'(rem_q) >= dsh_q;
    q_next   = {q_q[Q_W-2:0], ge};
    done     = busy_q && (cnt_q == CNT_W'(Q_W - 1));
    quotient = q_next;
    busy     = busy_q;
    rem_d    = rem_q;
    dsh_d    = dsh_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    // start wins over an in-flight division so back-to-back divisions lose no cycle
    if (start) begin
      rem_d  = dividend;
      dsh_d  = CW'(divisor) << (Q_W - 1);
      q_d    = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = ge ? NUM_W'(CW'(rem_q) - dsh_q) : rem_q;
      dsh_d  = dsh_q >> 1;
      q_d    = q_next;
      cnt_d  = cnt_q + CNT_W'(1);
      busy_d = !done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/layernorm_stats_stream.sv
// Streaming per-row mean / population variance ahead of LayerNorm.
// Row accumulation overlaps the two sequential divisions of the previous row.
module layernorm_stats_stream
  import layernorm_stats_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int INPUT_NUM   = DEFAULT_INPUT_NUM,
  parameter int LANES       = 16
) (
  input  logic                         clk_p,
  input  logic                         rst,
  input  logic [INPUT_WIDTH*LANES-1:0] data,
  input  logic                         data_valid_n,
  output logic                         data_ready,
  output logic [INPUT_WIDTH-1:0]       mean,
  output logic [2*INPUT_WIDTH-1:0]     variance,
  output logic                         stat_valid_n,
  input  logic                         stat_ready,
  output logic [2:0]                   state_dbg,
  output logic                         div_busy_dbg
);

  localparam int     BEATS = INPUT_NUM / LANES;
  localparam int     SUM_W = sum_width(INPUT_WIDTH, INPUT_NUM);
  localparam int     SQ_W  = sq_width(INPUT_WIDTH, INPUT_NUM);
  localparam int     NUM_W = 2 * SQ_W;
  localparam int     Q_W   = 2 * INPUT_WIDTH;
  localparam int     CNT_W = $clog2(BEATS);
  localparam longint N_SQ  = longint'(INPUT_NUM) * longint'(INPUT_NUM);
  localparam int     DEN_W = $clog2(N_SQ + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic signed [SUM_W-1:0] acc_sum_q, acc_sum_d, shadow_sum_q, shadow_sum_d, beat_sum;
  logic [SQ_W-1:0]         acc_sq_q, acc_sq_d, shadow_sq_q, shadow_sq_d, beat_sq;
  logic [NUM_W-1:0]        num_q, num_d, num_calc;
  logic signed [NUM_W-1:0] sum_ext, sum_sqr;
  logic [INPUT_WIDTH-1:0]  mean_q, mean_d;
  logic [Q_W-1:0]          var_q, var_d;
  logic signed [2*INPUT_WIDTH-1:0] lane;
  logic [2*INPUT_WIDTH-1:0]        lane_sq;
  logic [SUM_W-1:0]        abs_sum;
  logic                    beat_last, accept, last_acc;
  logic                    div_start, div_busy, div_done;
  logic [NUM_W-1:0]        div_num;
  logic [DEN_W-1:0]        div_den;
  logic [Q_W-1:0]          div_q;

  // A finished row may only land when the shadow is free, or frees this very cycle.
  assign beat_last  = beat_cnt_q == CNT_W'(BEATS - 1);
  assign data_ready = !(beat_last && state_q != ST_IDLE) || (state_q == ST_OUT && stat_ready);
  assign accept     = !data_valid_n && data_ready;
  assign last_acc   = accept && beat_last;

  always_comb begin
    beat_sum = '0;
    beat_sq  = '0;
    lane     = '0;
    lane_sq  = '0;
    for (int k = 0; k < LANES; k++) begin
      lane     = {{INPUT_WIDTH{data[(k+1)*INPUT_WIDTH-1]}}, data[k*INPUT_WIDTH +: INPUT_WIDTH]};
      lane_sq  = lane * lane;
      beat_sum = beat_sum + SUM_W'(lane);
      beat_sq  = beat_sq + SQ_W'(lane_sq);
    end
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    acc_sum_d    = acc_sum_q;
    acc_sq_d     = acc_sq_q;
    shadow_sum_d = shadow_sum_q;
    shadow_sq_d  = shadow_sq_q;
    if (accept) begin
      if (beat_last) begin
        shadow_sum_d = acc_sum_q + beat_sum;
        shadow_sq_d  = acc_sq_q + beat_sq;
        acc_sum_d    = '0;
        acc_sq_d     = '0;
        beat_cnt_d   = '0;
      end else begin
        acc_sum_d  = acc_sum_q + beat_sum;
        acc_sq_d   = acc_sq_q + beat_sq;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // N*sum(x^2) - sum(x)^2 equals N^2 * variance, so it is never negative.
  assign sum_ext  = NUM_W'(shadow_sum_q);
  assign sum_sqr  = sum_ext * sum_ext;
  assign num_calc = NUM_W'(INPUT_NUM) * NUM_W'(shadow_sq_q) - $unsigned(sum_sqr);
  assign abs_sum  = shadow_sum_q[SUM_W-1] ? $unsigned(-shadow_sum_q) : $unsigned(shadow_sum_q);
  assign div_num  = (state_q == ST_NUM) ? NUM_W'(abs_sum) : num_q;
  assign div_den  = (state_q == ST_NUM) ? DEN_W'(INPUT_NUM) : DEN_W'(N_SQ);

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    mean_d    = mean_q;
    var_d     = var_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE:     if (last_acc) state_d = ST_NUM;
      ST_NUM: begin
        num_d     = num_calc;
        div_start = 1'b1;
        state_d   = ST_DIV_MEAN;
      end
      ST_DIV_MEAN: if (div_done) begin
        mean_d    = shadow_sum_q[SUM_W-1] ? -div_q[INPUT_WIDTH-1:0] : div_q[INPUT_WIDTH-1:0];
        div_start = 1'b1;
        state_d   = ST_DIV_VAR;
      end
      ST_DIV_VAR:  if (div_done) begin
        var_d   = div_q;
        state_d = ST_OUT;
      end
      ST_OUT:      if (stat_ready) state_d = last_acc ? ST_NUM : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      acc_sum_q    <= '0;
      acc_sq_q     <= '0;
      shadow_sum_q <= '0;
      shadow_sq_q  <= '0;
      num_q        <= '0;
      mean_q       <= '0;
      var_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      acc_sum_q    <= acc_sum_d;
      acc_sq_q     <= acc_sq_d;
      shadow_sum_q <= shadow_sum_d;
      shadow_sq_q  <= shadow_sq_d;
      num_q        <= num_d;
      mean_q       <= mean_d;
      var_q        <= var_d;
    end
  end

  seq_restoring_div #(
    .NUM_W(NUM_W),
    .DEN_W(DEN_W),
    .Q_W  (Q_W)
  ) u_div (
    .clk     (clk_p),
    .rst     (rst),
    .start   (div_start),
    .dividend(div_num),
    .divisor (div_den),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  assign mean         = mean_q;
  assign variance     = var_q;
  assign stat_valid_n = !(state_q == ST_OUT);
  assign state_dbg    = state_q;
  assign div_busy_dbg = div_busy;

endmodule

// File: tb/tb_layernorm_stats_stream.sv
// Scoreboard bench for layernorm_stats_stream: directed rows with hand-computed mean/variance.
module tb_layernorm_stats_stream;
  localparam int IW    = 8;
  localparam int N     = 768;
  localparam int L     = 16;
  localparam int BEATS = N / L;
  localparam int QW    = 2 * IW;
  localparam int DW    = IW * L;
  localparam int LAT   = 33;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW-1:0]        data;
  logic                 data_valid_n;
  logic                 data_ready;
  logic signed [IW-1:0] mean;
  logic [QW-1:0]        variance;
  logic                 stat_valid_n;
  logic                 stat_ready;
  logic [2:0]           state_dbg;
  logic                 div_busy_dbg;

  layernorm_stats_stream dut (
    .clk_p       (clk),
    .rst         (rst),
    .data        (data),
    .data_valid_n(data_valid_n),
    .data_ready  (data_ready),
    .mean        (mean),
    .variance    (variance),
    .stat_valid_n(stat_valid_n),
    .stat_ready  (stat_ready),
    .state_dbg   (state_dbg),
    .div_busy_dbg(div_busy_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  logic signed [IW-1:0] exp_mean_q[$];
  logic [QW-1:0]        exp_var_q[$];
  int                   exp_t_q[$];
  bit                   seen = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: latency on first sight of a result, values on handshake
  always @(negedge clk) begin
    if (!rst && !stat_valid_n) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_t_q.size() == 0) check("unexpected_result", 1, 0);
        else check("latency", cyc - exp_t_q[0], LAT);
      end
      if (stat_ready) begin
        if (exp_mean_q.size() == 0) check("unexpected_handshake", 1, 0);
        else begin
          check("mean", mean, exp_mean_q[0]);
          check("var", variance, exp_var_q[0]);
          void'(exp_mean_q.pop_front());
          void'(exp_var_q.pop_front());
        end
        if (exp_t_q.size() != 0) void'(exp_t_q.pop_front());
        seen = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] make_beat(input int kind, input int a, input int b, input int beat);
    logic [DW-1:0] d;
    int v;
    d = '0;
    for (int k = 0; k < L; k++) begin
      case (kind)
        0:       v = (k % 2 == 0) ? a : b;
        1:       v = (beat < BEATS / 2) ? a : b;
        default: v = (beat == 0 && k == 0) ? a : b;
      endcase
      d[k*IW +: IW] = IW'(v);
    end
    return d;
  endfunction

  // driver tasks
  task automatic send_beat(input logic [DW-1:0] d, input bit last);
    int guard;
    @(negedge clk);
    data = d;
    data_valid_n = 1'b0;
    guard = 0;
    while (!data_ready && guard < 500) begin
      stall_cnt++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("ready_timeout", 0, 1);
    if (last) exp_t_q.push_back(cyc + 1);
    @(posedge clk);
  endtask

  task automatic send_row(input int kind, input int a, input int b, input int em, input int ev);
    exp_mean_q.push_back(IW'(em));
    exp_var_q.push_back(QW'(ev));
    for (int bt = 0; bt < BEATS; bt++) send_beat(make_beat(kind, a, b, bt), bt == BEATS - 1);
    #1 data_valid_n = 1'b1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_mean_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (exp_mean_q.size() != 0) check("drain_timeout", exp_mean_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_ready"}, data_ready, 1);
    check({tag, "_stat_valid_n"}, stat_valid_n, 1);
    check({tag, "_mean"}, mean, 0);
    check({tag, "_var"}, variance, 0);
  endtask

  // alternating a/b rows: mean = trunc((a+b)/2), var = floor((a-b)^2/4)
  int ta[10] = '{10, 7, -7, 0, -1, 100, 127, -128, 50, -3};
  int tb[10] = '{-10, 1, -1, 1, 0, -100, 127, 127, 20, -8};
  int tm[10] = '{0, 4, -4, 0, 0, 0, 127, 0, 35, -5};
  int tv[10] = '{100, 9, 9, 0, 0, 10000, 0, 16256, 225, 6};

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    data = '0;
    data_valid_n = 1'b1;
    stat_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;

    stall_cnt = 0;
    send_row(0, 5, 5, 5, 0);
    send_row(0, 3, -3, 0, 9);
    send_row(0, -128, -128, -128, 0);
    send_row(1, 127, -128, 0, 16256);
    send_row(2, -1, 0, 0, 0);
    for (int r = 0; r < 10; r++) send_row(0, ta[r], tb[r], tm[r], tv[r]);
    check("no_stall_streaming", stall_cnt, 0);
    drain();

    // back-pressure across two rows
    @(posedge clk);
    #1 stat_ready = 1'b0;
    send_row(0, 5, 5, 5, 0);
    stall_cnt = 0;
    fork
      send_row(0, 3, -3, 0, 9);
      begin
        repeat (70) @(posedge clk);
        #1 stat_ready = 1'b1;
      end
    join
    check("last_beat_stalled", stall_cnt > 0, 1);
    drain();

    // reset mid-row
    for (int bt = 0; bt < 20; bt++) send_beat(make_beat(0, 5, 5, bt), 1'b0);
    #1 data_valid_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_midrow");
    check("rst_midrow_state", state_dbg, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // reset at cycle 10 of the variance division
    send_row(0, 5, 5, 5, 0);
    repeat (27) @(negedge clk);
    check("pre_rst_mean", mean, 5);
    check("pre_rst_state", state_dbg, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_mean_q.delete();
    exp_var_q.delete();
    exp_t_q.delete();
    seen = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_div");
    check("rst_div_state", state_dbg, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send_row(0, 5, 5, 5, 0);
    drain();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
